// File: rtl/wb_stage_pipe.sv
// Write-back stage: pipeline register, load-data formatting,
// register-file write control and retired-instruction counting.
module wb_stage_pipe #(
    parameter  int DATA_W  = 32,
    parameter  int RADDR_W = 5,
    parameter  int CNT_W   = 32,
    localparam int OFF_W   = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         wb_sel,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd,
    input  logic [DATA_W-1:0]  alu_data_out,
    input  logic [DATA_W-1:0]  dm_data_out,
    input  logic [DATA_W-1:0]  link_pc,
    input  logic [DATA_W-1:0]  imm_data,
    input  logic [1:0]         ld_size,
    input  logic               ld_unsigned,
    input  logic [OFF_W-1:0]   ld_off,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  wb_data,
    output logic [CNT_W-1:0]   retire_cnt
);

    logic               r_valid;
    logic [1:0]         r_sel;
    logic               r_we;
    logic [RADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]  r_alu;
    logic [DATA_W-1:0]  r_dm;
    logic [DATA_W-1:0]  r_link;
    logic [DATA_W-1:0]  r_imm;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [OFF_W-1:0]   r_off;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_capture;
    logic               w_retire;
    logic [1:0]         w_esize;
    logic [OFF_W-1:0]   w_mask;
    logic [OFF_W-1:0]   w_aoff;
    logic [DATA_W-1:0]  w_sh;
    logic [DATA_W-1:0]  w_bext;
    logic [DATA_W-1:0]  w_hext;
    logic [DATA_W-1:0]  w_wext;
    logic [DATA_W-1:0]  w_load;
    logic               w_bs;
    logic               w_hs;

    assign in_ready  = !stall;
    assign w_capture = in_valid & !stall & !flush;
    assign w_retire  = r_valid & !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_alu  <= '0;
            r_dm   <= '0;
            r_link <= '0;
            r_imm  <= '0;
            r_size <= '0;
            r_uns  <= 1'b0;
            r_off  <= '0;
        end else if (w_capture) begin
            r_sel  <= wb_sel;
            r_we   <= reg_write;
            r_rd   <= rd;
            r_alu  <= alu_data_out;
            r_dm   <= dm_data_out;
            r_link <= link_pc;
            r_imm  <= imm_data;
            r_size <= ld_size;
            r_uns  <= ld_unsigned;
            r_off  <= ld_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_retire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A 32-bit datapath has no dword lane; treat it as a word access.
    assign w_esize = (DATA_W == 32 && r_size == 2'd3) ? 2'd2 : r_size;
    assign w_mask  = {OFF_W{1'b1}} << w_esize;
    assign w_aoff  = r_off & w_mask;
    assign w_sh    = r_dm >> {w_aoff, 3'b000};

    assign w_bs   = !r_uns & w_sh[7];
    assign w_hs   = !r_uns & w_sh[15];
    assign w_bext = {{(DATA_W - 8){w_bs}}, w_sh[7:0]};
    assign w_hext = {{(DATA_W - 16){w_hs}}, w_sh[15:0]};

    generate
        if (DATA_W == 64) begin : g_w64
            logic w_ws;
            assign w_ws   = !r_uns & w_sh[31];
            assign w_wext = {{(DATA_W - 32){w_ws}}, w_sh[31:0]};
        end else begin : g_w32
            assign w_wext = w_sh;
        end
    endgenerate

    always_comb begin
        w_load = w_sh;
        unique case (w_esize)
            2'd0:    w_load = w_bext;
            2'd1:    w_load = w_hext;
            2'd2:    w_load = w_wext;
            default: w_load = w_sh;
        endcase
    end

    always_comb begin
        wb_data = r_alu;
        unique case (1'b1)
            (r_sel == 2'd1): wb_data = w_load;
            (r_sel == 2'd2): wb_data = r_link;
            (r_sel == 2'd3): wb_data = r_imm;
            default:         wb_data = r_alu;
        endcase
    end

    assign rf_we      = r_valid & r_we & (r_rd != '0) & !stall;
    assign rf_waddr   = r_rd;
    assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_wb_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] alu_data_out;
    logic [31:0] dm_data_out;
    logic [31:0] link_pc;
    logic [31:0] imm_data;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [1:0]  ld_off;
    logic [63:0] h_alu;
    logic [63:0] h_dm;
    logic [63:0] h_link;
    logic [63:0] h_imm;
    logic [2:0]  h_off;

    logic        a_in_ready, a_rf_we;
    logic [4:0]  a_rf_waddr;
    logic [31:0] a_wb_data, a_retire_cnt;
    logic        c_in_ready, c_rf_we;
    logic [4:0]  c_rf_waddr;
    logic [31:0] c_wb_data;
    logic [3:0]  c_retire_cnt;
    logic        h_in_ready, h_rf_we;
    logic [4:0]  h_rf_waddr;
    logic [63:0] h_wb_data;
    logic [31:0] h_retire_cnt;

    int n_chk;
    int n_pass;

    bit          m_valid;
    logic [1:0]  m_sel, m_size, m_off;
    bit          m_we, m_uns;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_dm, m_link, m_imm;
    int unsigned m_cnt;

    wb_stage_pipe #(.DATA_W(32), .RADDR_W(5), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .stall(stall), .flush(flush), .wb_sel(wb_sel), .reg_write(reg_write),
        .rd(rd), .alu_data_out(alu_data_out), .dm_data_out(dm_data_out),
        .link_pc(link_pc), .imm_data(imm_data), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .ld_off(ld_off), .rf_we(a_rf_we),
        .rf_waddr(a_rf_waddr), .wb_data(a_wb_data), .retire_cnt(a_retire_cnt)
    );

    wb_stage_pipe #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .stall(stall), .flush(flush), .wb_sel(wb_sel), .reg_write(reg_write),
        .rd(rd), .alu_data_out(alu_data_out), .dm_data_out(dm_data_out),
        .link_pc(link_pc), .imm_data(imm_data), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .ld_off(ld_off), .rf_we(c_rf_we),
        .rf_waddr(c_rf_waddr), .wb_data(c_wb_data), .retire_cnt(c_retire_cnt)
    );

    wb_stage_pipe #(.DATA_W(64), .RADDR_W(5), .CNT_W(32)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
        .stall(stall), .flush(flush), .wb_sel(wb_sel), .reg_write(reg_write),
        .rd(rd), .alu_data_out(h_alu), .dm_data_out(h_dm),
        .link_pc(h_link), .imm_data(h_imm), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .ld_off(h_off), .rf_we(h_rf_we),
        .rf_waddr(h_rf_waddr), .wb_data(h_wb_data), .retire_cnt(h_retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference load: pick the aligned lane, then extend to the datapath.
    function automatic logic [63:0] ref_load(input int dw, input logic [63:0] dm,
                                             input int size, input bit uns, input int off);
        int nb;
        logic [63:0] v;
        logic [63:0] m;
        if (dw == 32 && size == 3) size = 2;
        nb  = 1 << size;
        off = off - (off % nb);
        v   = dm >> (8 * off);
        if (nb < 8) begin
            m = (64'd1 << (8 * nb)) - 64'd1;
            v = v & m;
            if (!uns && v[8 * nb - 1]) v = v | ~m;
        end
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [31:0] exp_wb();
        logic [63:0] t;
        t = ref_load(32, {32'd0, m_dm}, int'(m_size), m_uns, int'(m_off));
        case (m_sel)
            2'd0:    return m_alu;
            2'd1:    return t[31:0];
            2'd2:    return m_link;
            default: return m_imm;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_cnt = 0; m_sel = 0; m_size = 0; m_off = 0;
        m_we = 0; m_uns = 0; m_rd = 0;
        m_alu = 0; m_dm = 0; m_link = 0; m_imm = 0;
    endtask

    // Advance the model by one edge using the inputs as they stand, then the DUT.
    task automatic tick();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (m_valid && !stall) m_cnt++;
            if (flush) begin
                m_valid = 0;
            end else if (!stall) begin
                m_valid = in_valid;
                if (in_valid) begin
                    m_sel = wb_sel; m_we = reg_write; m_rd = rd;
                    m_alu = alu_data_out; m_dm = dm_data_out;
                    m_link = link_pc; m_imm = imm_data;
                    m_size = ld_size; m_uns = ld_unsigned; m_off = ld_off;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                         input logic [4:0] d, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [1:0] sz,
                         input logic un, input logic [1:0] off);
        in_valid = v; wb_sel = sel; reg_write = we; rd = d;
        alu_data_out = alu; dm_data_out = dm;
        ld_size = sz; ld_unsigned = un; ld_off = off;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        stall = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL reset_rf_we got %b exp 0", a_rf_we); else n_pass++;
        n_chk++; if (a_rf_waddr !== 5'd0) $display("FAIL reset_waddr got %h exp 0", a_rf_waddr); else n_pass++;
        n_chk++; if (a_wb_data !== 32'd0) $display("FAIL reset_wb_data got %h exp 0", a_wb_data); else n_pass++;
        n_chk++; if (a_retire_cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", a_retire_cnt); else n_pass++;
        n_chk++; if (h_wb_data !== 64'd0) $display("FAIL reset_wb_data64 got %h exp 0", h_wb_data); else n_pass++;
        stall = 1'b1;
        #1;
        n_chk++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready_stall got %b exp 0", a_in_ready); else n_pass++;
        stall = 1'b0;
        #1;
        n_chk++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", a_in_ready); else n_pass++;
        tick();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive(1, 2'd0, 1, 5'd3, 32'd5, 32'd4, 2'd2, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'd5) $display("FAIL alu_wb_data got %h exp 5", a_wb_data); else n_pass++;
        n_chk++; if (a_rf_we !== 1'b1) $display("FAIL alu_rf_we got %b exp 1", a_rf_we); else n_pass++;
        n_chk++; if (a_rf_waddr !== 5'd3) $display("FAIL alu_waddr got %0d exp 3", a_rf_waddr); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== 32'd1) $display("FAIL alu_cnt got %0d exp 1", a_retire_cnt); else n_pass++;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL alu_idle_we got %b exp 0", a_rf_we); else n_pass++;
    endtask

    task automatic test_loads();
        drive(1, 2'd1, 1, 5'd4, 32'd0, 32'h80FF7F01, 2'd0, 0, 2'd2);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'hFFFFFFFF) $display("FAIL lb_signed got %h exp FFFFFFFF", a_wb_data); else n_pass++;
        drive(1, 2'd1, 1, 5'd4, 32'd0, 32'h80FF7F01, 2'd0, 1, 2'd2);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'h000000FF) $display("FAIL lb_unsigned got %h exp 000000FF", a_wb_data); else n_pass++;
        drive(1, 2'd1, 1, 5'd4, 32'd0, 32'h80FF7F01, 2'd1, 0, 2'd2);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'hFFFF80FF) $display("FAIL lh_signed got %h exp FFFF80FF", a_wb_data); else n_pass++;
        drive(1, 2'd1, 1, 5'd4, 32'd0, 32'h80FF7F01, 2'd3, 1, 2'd3);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'h80FF7F01) $display("FAIL ld_on_32 got %h exp 80FF7F01", a_wb_data); else n_pass++;
        link_pc = 32'h0000_1004;
        imm_data = 32'hABCD_0000;
        drive(1, 2'd2, 1, 5'd1, 32'd9, 32'd8, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'h0000_1004) $display("FAIL link_sel got %h exp 00001004", a_wb_data); else n_pass++;
        drive(1, 2'd3, 1, 5'd1, 32'd9, 32'd8, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_wb_data !== 32'hABCD_0000) $display("FAIL imm_sel got %h exp ABCD0000", a_wb_data); else n_pass++;
        tick();
    endtask

    task automatic test_stall_flush();
        int unsigned base;
        base = m_cnt;
        drive(1, 2'd0, 1, 5'd7, 32'h1234, 32'd0, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (a_rf_we !== 1'b0) $display("FAIL stall_we[%0d] got %b exp 0", i, a_rf_we); else n_pass++;
            tick();
            n_chk++; if (a_retire_cnt !== base) $display("FAIL stall_cnt[%0d] got %0d exp %0d", i, a_retire_cnt, base); else n_pass++;
        end
        stall = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b1) $display("FAIL unstall_we got %b exp 1", a_rf_we); else n_pass++;
        n_chk++; if (a_wb_data !== 32'h1234) $display("FAIL unstall_data got %h exp 1234", a_wb_data); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== base + 1) $display("FAIL unstall_cnt got %0d exp %0d", a_retire_cnt, base + 1); else n_pass++;
        drive(1, 2'd0, 1, 5'd9, 32'h99, 32'd0, 2'd0, 0, 2'd0);
        tick();
        drive(1, 2'd0, 1, 5'd10, 32'hAA, 32'd0, 2'd0, 0, 2'd0);
        flush = 1'b1;
        #1;
        n_chk++; if (a_rf_we !== 1'b1) $display("FAIL flush_retire_we got %b exp 1", a_rf_we); else n_pass++;
        n_chk++; if (a_rf_waddr !== 5'd9) $display("FAIL flush_retire_addr got %0d exp 9", a_rf_waddr); else n_pass++;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL flush_kill_we got %b exp 0", a_rf_we); else n_pass++;
        n_chk++; if (a_retire_cnt !== base + 2) $display("FAIL flush_cnt got %0d exp %0d", a_retire_cnt, base + 2); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== base + 2) $display("FAIL flush_nocap_cnt got %0d exp %0d", a_retire_cnt, base + 2); else n_pass++;
        drive(1, 2'd0, 1, 5'd11, 32'hBB, 32'd0, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        tick();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL stall_flush_we got %b exp 0", a_rf_we); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== base + 2) $display("FAIL stall_flush_cnt got %0d exp %0d", a_retire_cnt, base + 2); else n_pass++;
    endtask

    task automatic test_x0_wrap();
        #2;
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
        drive(1, 2'd0, 1, 5'd0, 32'h77, 32'd0, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL x0_we got %b exp 0", a_rf_we); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== 32'd1) $display("FAIL x0_cnt got %0d exp 1", a_retire_cnt); else n_pass++;
        drive(1, 2'd0, 0, 5'd2, 32'h1, 32'd0, 2'd0, 0, 2'd0);
        for (int i = 0; i < 15; i++) tick();
        n_chk++; if (c_retire_cnt !== 4'd15) $display("FAIL wrap_pre got %0d exp 15", c_retire_cnt); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_chk++; if (c_retire_cnt !== 4'd0) $display("FAIL wrap_cnt4 got %0d exp 0", c_retire_cnt); else n_pass++;
        n_chk++; if (a_retire_cnt !== 32'd16) $display("FAIL wrap_cnt32 got %0d exp 16", a_retire_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1, 2'd0, 1, 5'd5, 32'h55, 32'd0, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b1) $display("FAIL rmid_pre_we got %b exp 1", a_rf_we); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b0) $display("FAIL rmid_we got %b exp 0", a_rf_we); else n_pass++;
        n_chk++; if (a_rf_waddr !== 5'd0) $display("FAIL rmid_waddr got %0d exp 0", a_rf_waddr); else n_pass++;
        n_chk++; if (a_wb_data !== 32'd0) $display("FAIL rmid_data got %h exp 0", a_wb_data); else n_pass++;
        n_chk++; if (a_retire_cnt !== 32'd0) $display("FAIL rmid_cnt got %0d exp 0", a_retire_cnt); else n_pass++;
        tick();
        #2;
        rst_n = 1'b1;
        n_chk++; if (a_retire_cnt !== 32'd0) $display("FAIL rmid_held_cnt got %0d exp 0", a_retire_cnt); else n_pass++;
        drive(1, 2'd0, 1, 5'd6, 32'd77, 32'd0, 2'd0, 0, 2'd0);
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (a_rf_we !== 1'b1) $display("FAIL rmid_first_we got %b exp 1", a_rf_we); else n_pass++;
        tick();
        n_chk++; if (a_retire_cnt !== 32'd1) $display("FAIL rmid_first_cnt got %0d exp 1", a_retire_cnt); else n_pass++;
    endtask

    task automatic test_dw64();
        logic [63:0] e;
        drive(1, 2'd1, 1, 5'd8, 32'd0, 32'd0, 2'd2, 0, 2'd0);
        h_dm = 64'h8000_0001_0000_0000;
        h_off = 3'd4;
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (h_wb_data !== 64'hFFFF_FFFF_8000_0001) $display("FAIL lw64_signed got %h exp FFFFFFFF80000001", h_wb_data); else n_pass++;
        ld_unsigned = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_chk++; if (h_wb_data !== 64'h0000_0000_8000_0001) $display("FAIL lwu64 got %h exp 0000000080000001", h_wb_data); else n_pass++;
        for (int i = 0; i < 24; i++) begin
            h_dm = {$urandom, $urandom};
            h_off = 3'($urandom_range(0, 7));
            ld_size = 2'($urandom_range(0, 3));
            ld_unsigned = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            #1;
            e = ref_load(64, h_dm, int'(ld_size), ld_unsigned, int'(h_off));
            n_chk++; if (h_wb_data !== e) $display("FAIL load64[%0d] size %0d off %0d got %h exp %h", i, ld_size, h_off, h_wb_data, e); else n_pass++;
        end
        tick();
    endtask

    task automatic test_random();
        logic e_we;
        logic [31:0] e_wb;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            stall = 1'($urandom_range(0, 3) == 0);
            flush = 1'($urandom_range(0, 9) == 0);
            wb_sel = 2'($urandom_range(0, 3));
            reg_write = 1'($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 31));
            alu_data_out = $urandom;
            dm_data_out = $urandom;
            link_pc = $urandom;
            imm_data = $urandom;
            ld_size = 2'($urandom_range(0, 3));
            ld_unsigned = 1'($urandom_range(0, 1));
            ld_off = 2'($urandom_range(0, 3));
            #1;
            e_we = m_valid && m_we && (m_rd != 5'd0) && !stall;
            n_chk++; if (a_rf_we !== e_we) $display("FAIL rnd_we[%0d] got %b exp %b", i, a_rf_we, e_we); else n_pass++;
            n_chk++; if (a_in_ready !== !stall) $display("FAIL rnd_ready[%0d] got %b exp %b", i, a_in_ready, !stall); else n_pass++;
            n_chk++; if (a_retire_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, a_retire_cnt, m_cnt); else n_pass++;
            n_chk++; if (c_retire_cnt !== 4'(m_cnt)) $display("FAIL rnd_cnt4[%0d] got %0d exp %0d", i, c_retire_cnt, 4'(m_cnt)); else n_pass++;
            if (m_valid) begin
                e_wb = exp_wb();
                n_chk++; if (a_wb_data !== e_wb) $display("FAIL rnd_data[%0d] sel %0d got %h exp %h", i, m_sel, a_wb_data, e_wb); else n_pass++;
                n_chk++; if (a_rf_waddr !== m_rd) $display("FAIL rnd_addr[%0d] got %0d exp %0d", i, a_rf_waddr, m_rd); else n_pass++;
            end
            tick();
        end
        in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_sel = 2'd0; reg_write = 1'b0; rd = 5'd0;
        alu_data_out = 32'd0; dm_data_out = 32'd0;
        link_pc = 32'd0; imm_data = 32'd0;
        ld_size = 2'd0; ld_unsigned = 1'b0; ld_off = 2'd0;
        h_alu = 64'd0; h_dm = 64'd0; h_link = 64'd0; h_imm = 64'd0;
        h_off = 3'd0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_stall_flush();
        test_x0_wrap();
        test_reset_mid();
        test_dw64();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 The parameter list SHALL be: DATA_W, 32, datapath width (legal values 32 or 64).
REQ-002 The parameter list SHALL include: RADDR_W, 5, register-file address width.
REQ-003 The parameter list SHALL include: CNT_W, 32, width of the retire counter.
REQ-004 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-005 Ports SHALL include: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports SHALL include: in_valid  in  1  MEM stage presents an instruction.
REQ-007 Ports SHALL include: in_ready  out  1  stage accepts input; equals !stall.
REQ-008 Ports SHALL include: stall  in  1  hold the pipeline register.
REQ-009 Ports SHALL include: flush  in  1  kill the held instruction.
REQ-010 Ports SHALL include: wb_sel  in  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 IMM.
REQ-011 Ports SHALL include: reg_write  in  1  instruction writes the register file.
REQ-012 Ports SHALL include: rd  in  RADDR_W  destination register.
REQ-013 Ports SHALL include: alu_data_out, dm_data_out, link_pc, imm_data  in  DATA_W each  candidate sources.
REQ-014 Ports SHALL include: ld_size  in  2  0 byte, 1 half, 2 word, 3 dword.
REQ-015 Ports SHALL include: ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
REQ-016 Ports SHALL include: ld_off  in  log2(DATA_W/8)  byte offset of the load.
REQ-017 Ports SHALL include: rf_we  out  1  register-file write enable.
REQ-018 Ports SHALL include: rf_waddr  out  RADDR_W  write address.
REQ-019 Ports SHALL include: wb_data  out  DATA_W  write data, also used as forwarding data.
REQ-020 Ports SHALL include: retire_cnt  out  CNT_W  count of retired instructions.

Function
REQ-021 On a rising edge with in_valid=1, stall=0 and flush=0, the stage SHALL capture all inputs into one pipeline register and set wb_valid=1.
REQ-022 On a rising edge with in_valid=0, stall=0 and flush=0, the stage SHALL set wb_valid=0.
REQ-023 With stall=1 and flush=0, the register and wb_valid SHALL hold their values.
REQ-024 flush=1 SHALL clear wb_valid on the next edge regardless of stall or in_valid, and SHALL NOT capture the input.
REQ-025 wb_data SHALL be a combinational function of the registered fields only, with no input-to-output combinational path, giving one cycle of latency.
REQ-026 wb_sel=0 SHALL select alu_data_out, 2 SHALL select link_pc, 3 SHALL select imm_data, and 1 SHALL select the formatted load value.
REQ-027 Load formatting SHALL extract the lane at ld_off, aligned down to the access size: byte [8*off+7:8*off], half at off&~1, word at off&~3, dword the full word.
REQ-028 Load formatting SHALL extend the extracted lane to DATA_W, using zero-extension when ld_unsigned=1 and sign-extension otherwise.
REQ-029 When DATA_W=32, ld_size=3 SHALL behave as ld_size=2.
REQ-030 When DATA_W=32 and ld_size is 2 or 3, ld_unsigned SHALL be ignored.
REQ-031 rf_we SHALL equal wb_valid & reg_write & (rd!=0) & !stall.
REQ-032 rf_waddr SHALL equal the registered rd.
REQ-033 An instruction SHALL retire on each cycle where wb_valid=1 and stall=0.
REQ-034 retire_cnt SHALL increment by 1 on each retire, including instructions with rd=0 or reg_write=0.
REQ-035 retire_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-036 When stall and retire coincide, stall SHALL suppress the retire: no count and no write.
REQ-037 A flush arriving while wb_valid=1 and stall=0 SHALL still let that instruction retire in the flush cycle; the flush only prevents new capture.

Reset
REQ-038 While rst_n=0, wb_valid, rf_we, rf_waddr, wb_data, all registered fields and retire_cnt SHALL be 0, asynchronously.
REQ-039 in_ready SHALL follow stall during reset.
REQ-040 Reset deassertion SHALL take effect on the first rising edge after rst_n goes high; there SHALL be no output glitch mid-cycle.
REQ-041 Reset asserted mid-operation SHALL discard the held instruction with no write.

Verification
REQ-042 The bench SHALL cover ALU path: wb_sel=0, alu_data_out=5, dm_data_out=4, rd=3, reg_write=1 -> one cycle later wb_data=5, rf_we=1, rf_waddr=3, retire_cnt=1.
REQ-043 The bench SHALL cover loads: dm_data_out=0x80FF7F01, ld_off=2, ld_size=0 -> wb_data=0xFFFFFFFF signed, 0x000000FF unsigned; ld_size=1, off=2, signed -> 0xFFFF80FF.
REQ-044 The bench SHALL cover stall/flush: capture, then stall=1 for 3 cycles -> rf_we=0 and retire_cnt unchanged; stall=0 -> one write, count+1; flush with in_valid=1 -> wb_valid=0 next cycle.
REQ-045 The bench SHALL cover the x0 and counter-wrap case: rd=0, reg_write=1 -> rf_we=0 but the count still increments; with CNT_W=4, 16 retires -> retire_cnt=0.
REQ-046 The bench SHALL cover reset mid-stream: rst_n=0 asserted between edges -> all outputs 0 immediately; the first valid after release retires with retire_cnt=1.
REQ-047 The bench SHALL cover DATA_W=64: ld_size=2, off=4, dm_data_out=0x8000000100000000, signed -> wb_data=0xFFFFFFFF80000001... upper lane sign-extended.
